// File: rtl/k_fetch_unit_if.sv
// rtl/k_fetch_unit_if.sv - fetch unit bus: instruction memory, redirect and decode handshake
//
// Groups every non-clock/reset signal of k_fetch_unit.
//   master : the fetch unit (drives imem_addr and out_*, receives imem_instr, redirect_*, out_ready)
//   slave  : the surroundings (memory, branch resolution, decode)
interface k_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/k_fetch_unit.sv
// rtl/k_fetch_unit.sv - instruction fetch stage: PC, fetch queue, redirect/flush
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - k_fetch_unit_if.master: imem_addr/imem_instr to instruction memory,
//          redirect_valid/redirect_pc from branch resolution,
//          out_valid/out_ready/out_instr/out_pc towards decode
module k_fetch_unit #(
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic           clk,
    input  logic           rst,
    k_fetch_unit_if.master bus
);
    localparam int AW = $clog2(IMEM_WORDS);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Queue storage is deliberately left out of reset; count_q alone decides validity.
    logic [AW-1:0] qpc_q    [QDEPTH];
    logic [31:0]   qinstr_q [QDEPTH];

    logic full;
    logic push;
    logic pop;

    // Push decision uses only registered count, so a pop cannot open a slot in a full queue
    // within the same cycle; this keeps out_ready off every combinational path.
    assign full = (count_q == CW'(QDEPTH));
    assign push = !rst && !bus.redirect_valid && !full;
    assign pop  = (count_q != '0) && bus.out_ready;

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst) begin
            pc_d    = AW'(RESET_PC);
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (bus.redirect_valid) begin
            // Flush: any same-cycle pop was already handed to decode, which discards it.
            pc_d    = bus.redirect_pc[AW-1:0];
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + AW'(1);
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[tail_q]    <= pc_q;
            qinstr_q[tail_q] <= bus.imem_instr;
        end
    end

    assign bus.imem_addr = 32'(pc_q);
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = qinstr_q[head_q];
    assign bus.out_pc    = 32'(qpc_q[head_q]);
endmodule
